sync_r2w_stat: RTL and testbench

SYNC_R2W_STAT -- requirements
Module: sync_r2w_stat

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/sync_cell.sv | 39 +++
 rtl/sync_r2w_stat.sv | 90 +++++++++
 tb/tb_sync_r2w_stat.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer path: Gray/binary conversion,
// popcount, and the legal synchronizer depth range.
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Helpers work on a fixed wide vector; callers zero-extend and size-cast back.
  localparam int FN_W = 32;

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [FN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < FN_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_cell.sv
// N-stage vector flop synchronizer with asynchronous active-low reset.
// Only stage 0 samples the foreign-domain input.
module sync_cell
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("sync_cell: STAGES=%0d outside legal range %0d..%0d",
             STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end
  endgenerate

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_r2w_stat.sv
// Read-to-write pointer synchronizer with writer-side fill/full/almost-full
// status and a sticky pointer-integrity error flag.
module sync_r2w_stat
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic [ADDR_WIDTH:0] rptr,
  input  logic [ADDR_WIDTH:0] wbin_next,
  input  logic [ADDR_WIDTH:0] afull_thresh,
  input  logic                clr_err,
  output logic [ADDR_WIDTH:0] wq2_rptr,
  output logic [ADDR_WIDTH:0] rbin_sync,
  output logic [ADDR_WIDTH:0] wfill,
  output logic                wfull,
  output logic                walmost_full,
  output logic                ptr_err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  generate
    if (ADDR_WIDTH < 1 || PW > FN_W) begin : g_bad_addr
      $error("sync_r2w_stat: ADDR_WIDTH=%0d unsupported", ADDR_WIDTH);
    end
    if (DATA_WIDTH < 1) begin : g_bad_data
      $error("sync_r2w_stat: DATA_WIDTH=%0d must be positive", DATA_WIDTH);
    end
  endgenerate

  sync_cell #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i   (wclk),
    .rst_n_i (wrst_n),
    .d_i     (rptr),
    .q_o     (wq2_rptr)
  );

  assign rbin_sync = PW'(gray2bin(FN_W'(wq2_rptr)));

  logic [PW-1:0] prev_q, prev_d;
  logic [PW-1:0] wfill_q, wfill_d;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          ptr_err_q, ptr_err_d;
  logic [PW-1:0] next_fill;
  logic          hop_err;
  logic          err_set;

  // Wrap-around needs no special case: the subtraction is modulo 2^PW.
  always_comb begin
    next_fill      = wbin_next - rbin_sync;
    hop_err        = popcount(FN_W'(wq2_rptr ^ prev_q)) > 32'd1;
    err_set        = (next_fill > DEPTH) || hop_err;
    prev_d         = wq2_rptr;
    wfill_d        = next_fill;
    wfull_d        = (next_fill == DEPTH);
    walmost_full_d = (next_fill >= afull_thresh);
    ptr_err_d      = err_set || (ptr_err_q && !clr_err);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      prev_q         <= '0;
      wfill_q        <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      ptr_err_q      <= 1'b0;
    end else begin
      prev_q         <= prev_d;
      wfill_q        <= wfill_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      ptr_err_q      <= ptr_err_d;
    end
  end

  assign wfill        = wfill_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_sync_r2w_stat.sv
// Directed bench for sync_r2w_stat; two instances (2- and 4-stage sync)
// share one stimulus set.
module tb_sync_r2w_stat;

  logic       wclk;
  logic       wrst_n;
  logic [4:0] rptr;
  logic [4:0] wbin_next;
  logic [4:0] afull_thresh;
  logic       clr_err;

  logic [4:0] wq2_a, rbin_a, wfill_a;
  logic       wfull_a, waf_a, err_a;
  logic [4:0] wq2_b, rbin_b, wfill_b;
  logic       wfull_b, waf_b, err_b;

  int checks = 0;
  int errors = 0;

  sync_r2w_stat #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wbin_next(wbin_next),
    .afull_thresh(afull_thresh), .clr_err(clr_err),
    .wq2_rptr(wq2_a), .rbin_sync(rbin_a), .wfill(wfill_a),
    .wfull(wfull_a), .walmost_full(waf_a), .ptr_err(err_a)
  );

  sync_r2w_stat #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .SYNC_STAGES(4)) dut4 (
    .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wbin_next(wbin_next),
    .afull_thresh(afull_thresh), .clr_err(clr_err),
    .wq2_rptr(wq2_b), .rbin_sync(rbin_b), .wfill(wfill_b),
    .wfull(wfull_b), .walmost_full(waf_b), .ptr_err(err_b)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic tick(input int n);
    repeat (n) @(negedge wclk);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    rptr = 5'd0; wbin_next = 5'd0; afull_thresh = 5'd8; clr_err = 1'b0;
    wrst_n = 1'b0;
    tick(2);
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n = 1'b0; rptr = 5'd0; wbin_next = 5'd0; afull_thresh = 5'd8; clr_err = 1'b0;
    #2;
    checks++;
    if ({wq2_a, rbin_a, wfill_a, wfull_a, waf_a, err_a} !== 18'd0) begin
      errors++; $display("FAIL reset_outputs_a: got %h required 0", {wq2_a, rbin_a, wfill_a, wfull_a, waf_a, err_a});
    end
    checks++;
    if ({wq2_b, rbin_b, wfill_b, wfull_b, waf_b, err_b} !== 18'd0) begin
      errors++; $display("FAIL reset_outputs_b: got %h required 0", {wq2_b, rbin_b, wfill_b, wfull_b, waf_b, err_b});
    end
    tick(2);
    wrst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick(1);
      checks++;
      if (wfill_a !== 5'd0 || wfull_a !== 1'b0 || err_a !== 1'b0 || waf_a !== 1'b0) begin
        errors++; $display("FAIL idle_cycle%0d: fill=%0d full=%0b af=%0b err=%0b required all 0", c, wfill_a, wfull_a, waf_a, err_a);
      end
    end
  endtask

  task automatic test_sync_latency();
    do_reset();
    wbin_next = 5'd2; afull_thresh = 5'd8;
    tick(3);
    checks++;
    if (rbin_a !== 5'd0) begin
      errors++; $display("FAIL rbin_initial: got %0d required 0", rbin_a);
    end
    rptr = 5'd1;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      checks++;
      if (wq2_a !== ((c >= 2) ? 5'd1 : 5'd0)) begin
        errors++; $display("FAIL lat2_step1_c%0d: got %0d required %0d", c, wq2_a, (c >= 2) ? 1 : 0);
      end
      checks++;
      if (wq2_b !== ((c >= 4) ? 5'd1 : 5'd0)) begin
        errors++; $display("FAIL lat4_step1_c%0d: got %0d required %0d", c, wq2_b, (c >= 4) ? 1 : 0);
      end
    end
    checks++;
    if (rbin_a !== 5'd1 || rbin_b !== 5'd1) begin
      errors++; $display("FAIL rbin_one: got %0d/%0d required 1", rbin_a, rbin_b);
    end
    rptr = 5'd3;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      checks++;
      if (rbin_a !== ((c >= 2) ? 5'd2 : 5'd1)) begin
        errors++; $display("FAIL lat2_step2_c%0d: got rbin %0d required %0d", c, rbin_a, (c >= 2) ? 2 : 1);
      end
      checks++;
      if (wq2_b !== ((c >= 4) ? 5'd3 : 5'd1)) begin
        errors++; $display("FAIL lat4_step2_c%0d: got %0d required %0d", c, wq2_b, (c >= 4) ? 3 : 1);
      end
    end
    checks++;
    if (err_a !== 1'b0 || err_b !== 1'b0 || wfill_a !== 5'd0) begin
      errors++; $display("FAIL clean_steps: err=%0b/%0b fill=%0d required 0/0 0", err_a, err_b, wfill_a);
    end
  endtask

  task automatic test_full_afull();
    do_reset();
    wbin_next = 5'd16; afull_thresh = 5'd8;
    tick(1);
    checks++;
    if (wfill_a !== 5'd16 || wfull_a !== 1'b1 || waf_a !== 1'b1 || err_a !== 1'b0) begin
      errors++; $display("FAIL full16: fill=%0d full=%0b af=%0b err=%0b required 16 1 1 0", wfill_a, wfull_a, waf_a, err_a);
    end
    wbin_next = 5'd14; afull_thresh = 5'd14;
    tick(1);
    checks++;
    if (wfill_a !== 5'd14 || wfull_a !== 1'b0 || waf_a !== 1'b1) begin
      errors++; $display("FAIL afull14: fill=%0d full=%0b af=%0b required 14 0 1", wfill_a, wfull_a, waf_a);
    end
    afull_thresh = 5'd15;
    tick(1);
    checks++;
    if (waf_a !== 1'b0) begin
      errors++; $display("FAIL afull_below: got %0b required 0", waf_a);
    end
    wbin_next = 5'd0; afull_thresh = 5'd0;
    tick(1);
    checks++;
    if (waf_a !== 1'b1 || wfill_a !== 5'd0) begin
      errors++; $display("FAIL afull_thresh0: af=%0b fill=%0d required 1 0", waf_a, wfill_a);
    end
    wbin_next = 5'd16; afull_thresh = 5'd17;
    tick(1);
    checks++;
    if (waf_a !== 1'b0 || wfull_a !== 1'b1 || err_a !== 1'b0) begin
      errors++; $display("FAIL afull_thresh17: af=%0b full=%0b err=%0b required 0 1 0", waf_a, wfull_a, err_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rptr = 5'h11; wbin_next = 5'd0; afull_thresh = 5'd20;
    tick(4);
    checks++;
    if (err_a !== 1'b1) begin
      errors++; $display("FAIL wrap_jump_err: got %0b required 1", err_a);
    end
    clr_err = 1'b1; wbin_next = 5'd2;
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (wfill_a !== 5'd4 || wfull_a !== 1'b0 || err_a !== 1'b0 || rbin_a !== 5'd30) begin
      errors++; $display("FAIL wrap_fill4: fill=%0d full=%0b err=%0b rbin=%0d required 4 0 0 30", wfill_a, wfull_a, err_a, rbin_a);
    end
    wbin_next = 5'd14;
    tick(1);
    checks++;
    if (wfill_a !== 5'd16 || wfull_a !== 1'b1 || err_a !== 1'b0) begin
      errors++; $display("FAIL wrap_full: fill=%0d full=%0b err=%0b required 16 1 0", wfill_a, wfull_a, err_a);
    end
    wbin_next = 5'd15;
    tick(1);
    checks++;
    if (wfill_a !== 5'd17 || wfull_a !== 1'b0 || err_a !== 1'b1) begin
      errors++; $display("FAIL wrap_overflow: fill=%0d full=%0b err=%0b required 17 0 1", wfill_a, wfull_a, err_a);
    end
  endtask

  task automatic test_ptr_err();
    do_reset();
    afull_thresh = 5'd8;
    rptr = 5'd3; wbin_next = 5'd2;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      checks++;
      if (err_a !== ((c >= 3) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL hop_err2_c%0d: got %0b required %0b", c, err_a, (c >= 3) ? 1'b1 : 1'b0);
      end
      checks++;
      if (err_b !== ((c >= 5) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL hop_err4_c%0d: got %0b required %0b", c, err_b, (c >= 5) ? 1'b1 : 1'b0);
      end
    end
    clr_err = 1'b1;
    tick(1);
    checks++;
    if (err_a !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL clr_err: got %0b/%0b required 0/0", err_a, err_b);
    end
    wbin_next = 5'd20;
    tick(1);
    checks++;
    if (err_a !== 1'b1 || err_b !== 1'b1) begin
      errors++; $display("FAIL set_beats_clear: got %0b/%0b required 1/1", err_a, err_b);
    end
    wbin_next = 5'd2; clr_err = 1'b0;
    tick(2);
    checks++;
    if (err_a !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %0b required 1", err_a);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (err_a !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL clr_err2: got %0b/%0b required 0/0", err_a, err_b);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    rptr = 5'd0; wbin_next = 5'd16; afull_thresh = 5'd4;
    tick(3);
    checks++;
    if (wfull_a !== 1'b1 || wfull_b !== 1'b1) begin
      errors++; $display("FAIL pre_reset_full: got %0b/%0b required 1/1", wfull_a, wfull_b);
    end
    rptr = 5'd1;
    @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1;
    checks++;
    if ({wq2_a, rbin_a, wfill_a, wfull_a, waf_a, err_a} !== 18'd0) begin
      errors++; $display("FAIL async_reset_a: got %h required 0", {wq2_a, rbin_a, wfill_a, wfull_a, waf_a, err_a});
    end
    checks++;
    if ({wq2_b, rbin_b, wfill_b, wfull_b, waf_b, err_b} !== 18'd0) begin
      errors++; $display("FAIL async_reset_b: got %h required 0", {wq2_b, rbin_b, wfill_b, wfull_b, waf_b, err_b});
    end
    tick(1);
    wrst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      checks++;
      if (wq2_a !== ((c >= 2) ? 5'd1 : 5'd0)) begin
        errors++; $display("FAIL resync2_c%0d: got %0d required %0d", c, wq2_a, (c >= 2) ? 1 : 0);
      end
      checks++;
      if (wq2_b !== ((c >= 4) ? 5'd1 : 5'd0)) begin
        errors++; $display("FAIL resync4_c%0d: got %0d required %0d", c, wq2_b, (c >= 4) ? 1 : 0);
      end
    end
    checks++;
    if (wfill_a !== 5'd15 || err_a !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL post_resync: fill=%0d err=%0b/%0b required 15 0/0", wfill_a, err_a, err_b);
    end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_full_afull();
    test_wrap();
    test_ptr_err();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
